btn_event_decoder: RTL and testbench
====================================

# btn_event_decoder

Consumer-side decoder for the auto-repeat pulse stream produced by the button debouncer. It turns single-cycle pulses (first pulse on press, then accelerating repeats while held) back into discrete button events: press, repeat, release, plus a held level, a repeat count and an acceleration step. A counter or menu FSM uses it to act on user input without timing the pulse train itself.

## Interface
- `GAP_TIMEOUT`, 100000000: cycles without a pulse after which the button counts as released. Must exceed the debouncer's longest inter-pulse gap (99,000,000 cycles at 100 MHz).
- `REPEAT_W`, 8: width of `repeat_cnt`.
- `FAST_AFTER`, 4: `repeat_cnt` threshold for step 4.
- `FASTER_AFTER`, 16: `repeat_cnt` threshold for step 8. Must be greater than `FAST_AFTER`.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-low reset. Sampled on the `clk` rising edge; low means reset.
- `pulse_in` in 1: single-cycle pulse from the debouncer `clean` output.
- `press` out 1: one-cycle strobe on the first pulse of a hold.
- `repeat_stb` out 1: one-cycle strobe on each later pulse of the same hold.
- `release` out 1: one-cycle strobe when the gap timeout expires.
- `held` out 1: level, high from press until release.
- `event_stb` out 1: `press | repeat_stb`.
- `repeat_cnt` out REPEAT_W: number of repeats in the current hold; saturates at all-ones.
- `step` out 4: increment size qualified by `event_stb`; value is 1, 4 or 8.

## Operation
- FSM has two states, IDLE and HELD.
- Reset value of every output is 0. State is IDLE; gap counter is 0.
- **IDLE, `pulse_in`=1:**
  - assert `press`, `event_stb` and `held`;
  - `step`=1, `repeat_cnt`=0;
  - clear gap counter; go to HELD.
- **HELD, `pulse_in`=1:**
  - assert `repeat_stb` and `event_stb`;
  - `repeat_cnt` increments and saturates at 2^REPEAT_W−1;
  - clear gap counter.
- **Step selection in HELD**, using the post-increment count:
  - `step`=8 if count ≥ FASTER_AFTER;
  - else `step`=4 if count ≥ FAST_AFTER;
  - else `step`=1.
- **HELD, `pulse_in`=0:**
  - gap counter increments;
  - when it reaches GAP_TIMEOUT−1, assert `release`, clear `held`, zero `repeat_cnt`, go to IDLE.
- **Simultaneous pulse and timeout:** the pulse wins. It is treated as a repeat, the gap counter clears and no release is issued.
- **Gap counter:** width is $clog2(GAP_TIMEOUT). It never wraps, because it clears or leaves HELD at the terminal count.
- **Strobes:** `press`, `repeat_stb`, `release` and `event_stb` are high for exactly one cycle. `press` and `release` are never high in the same cycle.
- **Idle outputs:** `step` holds its last value when `event_stb` is low; consumers must qualify it with `event_stb`.
- **Reset mid-hold:** return to IDLE with all outputs 0. No `release` strobe is emitted.

## Timing
- All outputs are registered. Latency is one cycle: `pulse_in` high in cycle t gives `press` or `repeat_stb` high in cycle t+1.
- Release timing:
  - last pulse in cycle t, `pulse_in` low in cycles t+1 … t+GAP_TIMEOUT;
  - `release` high in cycle t+GAP_TIMEOUT+1;
  - `held` low from cycle t+GAP_TIMEOUT+1.
- A pulse in cycle t+GAP_TIMEOUT cancels the release.
- Back-to-back pulses in adjacent cycles are accepted. Each one produces its own strobe.
- A pulse in the same cycle as a `release` strobe, or in any later cycle, starts a new hold with `press` on the next cycle.

## Structure
- Shared package `btn_event_pkg` holds:
  - the state encoding (IDLE, HELD);
  - step constants (1, 4, 8);
  - the default GAP_TIMEOUT for a 100 MHz clock.
- One sub-module, `gap_timer`. It is a loadable up-counter with inputs `clear` and `enable`, and a terminal-count output `expired` at GAP_TIMEOUT−1.
- FSM, `repeat_cnt` and step logic live in the top level.

## Test plan
Bench parameters: GAP_TIMEOUT=16, FAST_AFTER=2, FASTER_AFTER=4, REPEAT_W=3.
- **Reset:** hold `reset`=0 for 3 cycles while `pulse_in`=1 → all outputs 0 throughout; first pulse after reset release gives `press`.
- **Single press:** one pulse at cycle 10 →
  - `press`=1, `step`=1 at cycle 11; `held`=1 from cycle 11;
  - `release`=1 at cycle 27; `held`=0 at cycle 27.
- **Repeat acceleration:** 6 pulses spaced 5 cycles apart → `step` sequence is 1, 1, 4, 4, 8, 8; `repeat_cnt` goes 0..5.
- **Saturation:** 10 pulses spaced 3 cycles apart → `repeat_cnt` stops at 7; `step` stays 8.
- **Pulse at timeout boundary:** pulse at cycle 0, then a pulse at cycle 16 → `repeat_stb` at cycle 17; no `release`; next release 16 cycles later.
- **Reset mid-hold:** press, then `reset`=0 at cycle 5 → outputs 0 next cycle; `release` never asserted.

Source files
------------

// File: rtl/btn_event_decoder_pkg.sv
// Shared definitions for the button event decoder: FSM state encoding,
// step increments and the default release timeout for a 100 MHz clock.
package btn_event_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    localparam logic [3:0] STEP_1 = 4'd1;
    localparam logic [3:0] STEP_4 = 4'd4;
    localparam logic [3:0] STEP_8 = 4'd8;

    // One second of silence at 100 MHz; longer than the debouncer's
    // slowest repeat interval (0.99 s), so a held button never times out.
    localparam int unsigned GAP_TIMEOUT_DEFAULT = 100_000_000;

    // Increment size for a given (post-increment) repeat count.
    function automatic logic [3:0] step_for(
        input int unsigned count,
        input int unsigned fast_after,
        input int unsigned faster_after
    );
        if (count >= faster_after) begin
            return STEP_8;
        end else if (count >= fast_after) begin
            return STEP_4;
        end
        return STEP_1;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// Event bus between the decoder (master) and its consumer (slave).
// pulse_in comes from the debouncer; everything else is decoder output.
// The release strobe is named release_stb because 'release' is reserved.
interface btn_event_decoder_if #(
    parameter int unsigned REPEAT_W = 8
);
    logic                pulse_in;
    logic                press;
    logic                repeat_stb;
    logic                release_stb;
    logic                held;
    logic                event_stb;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic [3:0]          step;

    modport master (
        input  pulse_in,
        output press,
        output repeat_stb,
        output release_stb,
        output held,
        output event_stb,
        output repeat_cnt,
        output step
    );

    modport slave (
        output pulse_in,
        input  press,
        input  repeat_stb,
        input  release_stb,
        input  held,
        input  event_stb,
        input  repeat_cnt,
        input  step
    );
endinterface

// File: rtl/btn_event_decoder_gap_timer.sv
// Counts idle cycles between pulses. 'clear' reloads zero, 'enable' counts
// up, and 'expired' flags the terminal count GAP_TIMEOUT-1. The counter
// returns to zero on its own at terminal count so it never wraps.
module gap_timer #(
    parameter int unsigned GAP_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(GAP_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(GAP_TIMEOUT - 1));

    // Loadable up-counter with self-clear at terminal count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (expired) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debouncer's auto-repeat pulse train back into press / repeat /
// release events with a held level, a saturating repeat count and an
// acceleration step. All outputs are registered, one cycle after pulse_in.
module btn_event_decoder
    import btn_event_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT  = GAP_TIMEOUT_DEFAULT,
    parameter int unsigned REPEAT_W     = 8,
    parameter int unsigned FAST_AFTER   = 4,
    parameter int unsigned FASTER_AFTER = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_event_decoder_if.master  bus
);
    state_t              state;
    logic                gap_expired;
    logic [REPEAT_W-1:0] cnt;
    logic [REPEAT_W-1:0] cnt_next;
    logic                press_q;
    logic                repeat_q;
    logic                release_q;
    logic                held_q;
    logic                event_q;
    logic [3:0]          step_q;

    // A pulse always restarts the gap; counting only happens while held.
    gap_timer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.pulse_in),
        .enable  (state == ST_HELD),
        .expired (gap_expired)
    );

    // Saturating post-increment repeat count.
    always_comb begin
        cnt_next = cnt;
        if (cnt != '1) begin
            cnt_next = cnt + REPEAT_W'(1);
        end
    end

    // IDLE/HELD FSM with registered strobes, count and step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
            event_q   <= 1'b0;
            cnt       <= '0;
            step_q    <= '0;
        end else begin
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            event_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.pulse_in) begin
                        press_q <= 1'b1;
                        event_q <= 1'b1;
                        held_q  <= 1'b1;
                        step_q  <= STEP_1;
                        cnt     <= '0;
                        state   <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    // A pulse on the terminal-count cycle wins over release.
                    if (bus.pulse_in) begin
                        repeat_q <= 1'b1;
                        event_q  <= 1'b1;
                        cnt      <= cnt_next;
                        step_q   <= step_for(32'(cnt_next), FAST_AFTER, FASTER_AFTER);
                    end else if (gap_expired) begin
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.press       = press_q;
    assign bus.repeat_stb  = repeat_q;
    assign bus.release_stb = release_q;
    assign bus.held        = held_q;
    assign bus.event_stb   = event_q;
    assign bus.repeat_cnt  = cnt;
    assign bus.step        = step_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with GAP_TIMEOUT=16, FAST_AFTER=2,
// FASTER_AFTER=4, REPEAT_W=3. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so "cycle k" below means the
// interval following the k-th edge after a stimulus started.
module tb_btn_event_decoder;

    localparam int unsigned G  = 16;
    localparam int unsigned RW = 3;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    btn_event_decoder_if #(.REPEAT_W(RW)) bus ();

    btn_event_decoder #(
        .GAP_TIMEOUT (G),
        .REPEAT_W    (RW),
        .FAST_AFTER  (2),
        .FASTER_AFTER(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Flag order: press, repeat, release, held, event.
    logic [4:0] flags;
    assign flags = {bus.press, bus.repeat_stb, bus.release_stb, bus.held, bus.event_stb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.pulse_in = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.pulse_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (flags !== 5'b00000 || bus.repeat_cnt !== 3'd0 || bus.step !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d flags=%b cnt=%0d step=%0d expected flags=00000 cnt=0 step=0",
                         k, flags, bus.repeat_cnt, bus.step);
            end
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (flags !== 5'b10011 || bus.step !== 4'd1 || bus.repeat_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_first_press flags=%b step=%0d cnt=%0d expected flags=10011 step=1 cnt=0",
                     flags, bus.step, bus.repeat_cnt);
        end
        bus.pulse_in = 1'b0;
    endtask

    task automatic test_single_press();
        logic [4:0] exp;
        do_reset();
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        for (int k = 1; k <= int'(G) + 3; k++) begin
            exp = {k == 1, 1'b0, k == int'(G) + 1, k <= int'(G), k == 1};
            vectors++;
            if (flags !== exp) begin
                miscompares++;
                $display("FAIL single_press cyc=%0d flags=%b expected %b", k, flags, exp);
            end
            if (k == 1) begin
                vectors++;
                if (bus.step !== 4'd1 || bus.repeat_cnt !== 3'd0) begin
                    miscompares++;
                    $display("FAIL single_press_step step=%0d cnt=%0d expected step=1 cnt=0",
                             bus.step, bus.repeat_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_repeat_accel();
        logic [3:0] exp_step [6] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd8, 4'd8};
        logic [4:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.pulse_in = 1'b1;
            tick();
            bus.pulse_in = 1'b0;
            exp = (i == 0) ? 5'b10011 : 5'b01011;
            vectors++;
            if (flags !== exp || bus.step !== exp_step[i] || bus.repeat_cnt !== 3'(i)) begin
                miscompares++;
                $display("FAIL repeat_accel pulse=%0d flags=%b step=%0d cnt=%0d expected flags=%b step=%0d cnt=%0d",
                         i, flags, bus.step, bus.repeat_cnt, exp, exp_step[i], i);
            end
            for (int j = 0; j < 4; j++) tick();
            vectors++;
            if (flags !== 5'b00010 || bus.step !== exp_step[i]) begin
                miscompares++;
                $display("FAIL repeat_hold pulse=%0d flags=%b step=%0d expected flags=00010 step=%0d",
                         i, flags, bus.step, exp_step[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_cnt  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
        logic [3:0] exp_step [10] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.pulse_in = 1'b1;
            tick();
            bus.pulse_in = 1'b0;
            vectors++;
            if (bus.repeat_cnt !== exp_cnt[i] || bus.step !== exp_step[i] || bus.event_stb !== 1'b1) begin
                miscompares++;
                $display("FAIL saturation pulse=%0d cnt=%0d step=%0d ev=%b expected cnt=%0d step=%0d ev=1",
                         i, bus.repeat_cnt, bus.step, bus.event_stb, exp_cnt[i], exp_step[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        for (int k = 1; k < int'(G); k++) begin
            vectors++;
            if (bus.release_stb !== 1'b0 || bus.held !== 1'b1) begin
                miscompares++;
                $display("FAIL boundary_hold cyc=%0d rel=%b held=%b expected rel=0 held=1",
                         k, bus.release_stb, bus.held);
            end
            tick();
        end
        // Cycle G: pulse on the terminal-count cycle.
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        vectors++;
        if (flags !== 5'b01011 || bus.repeat_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL boundary_repeat flags=%b cnt=%0d expected flags=01011 cnt=1",
                     flags, bus.repeat_cnt);
        end
        for (int k = int'(G) + 2; k <= 2 * int'(G) + 2; k++) begin
            tick();
            vectors++;
            if (bus.release_stb !== (k == 2 * int'(G) + 1) || bus.held !== (k < 2 * int'(G) + 1)) begin
                miscompares++;
                $display("FAIL boundary_release cyc=%0d rel=%b held=%b expected rel=%b held=%b",
                         k, bus.release_stb, bus.held, k == 2 * int'(G) + 1, k < 2 * int'(G) + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        do_reset();
        bus.pulse_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = (i == 0) ? 5'b10011 : 5'b01011;
            vectors++;
            if (flags !== exp || bus.repeat_cnt !== 3'(i)) begin
                miscompares++;
                $display("FAIL back_to_back pulse=%0d flags=%b cnt=%0d expected flags=%b cnt=%0d",
                         i, flags, bus.repeat_cnt, exp, i);
            end
        end
        bus.pulse_in = 1'b0;
    endtask

    task automatic test_restart_on_release();
        do_reset();
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        for (int k = 1; k <= int'(G); k++) tick();
        vectors++;
        if (flags !== 5'b00100) begin
            miscompares++;
            $display("FAIL restart_release flags=%b expected 00100", flags);
        end
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        vectors++;
        if (flags !== 5'b10011 || bus.step !== 4'd1) begin
            miscompares++;
            $display("FAIL restart_press flags=%b step=%0d expected flags=10011 step=1",
                     flags, bus.step);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        bus.pulse_in = 1'b1;
        tick();
        bus.pulse_in = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if (flags !== 5'b00000 || bus.repeat_cnt !== 3'd0 || bus.step !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_hold_reset flags=%b cnt=%0d step=%0d expected flags=00000 cnt=0 step=0",
                     flags, bus.repeat_cnt, bus.step);
        end
        for (int k = 0; k < int'(G) + 4; k++) begin
            tick();
            vectors++;
            if (bus.release_stb !== 1'b0 || bus.held !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_hold_no_release cyc=%0d rel=%b held=%b expected rel=0 held=0",
                         k, bus.release_stb, bus.held);
            end
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        bus.pulse_in = 1'b0;
        test_reset();
        test_single_press();
        test_repeat_accel();
        test_saturation();
        test_timeout_boundary();
        test_back_to_back();
        test_restart_on_release();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
